// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access sequencer.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Undefined load codes fall back to a word access.
  function automatic logic [1:0] ld_acc_size(input logic [2:0] funct3);
    case (funct3)
      LD_LB, LD_LBU: return SZ_BYTE;
      LD_LH, LD_LHU: return SZ_HALF;
      default:       return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] acc_size, input logic [1:0] addr_lo);
    case (acc_size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_align_unit.sv
// Combinational byte-lane steering: byte enables and replicated store data,
// plus load alignment with sign/zero extension.
module mem_align_unit
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  acc_size,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  input  logic [2:0]  ld_funct3,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    be    = 4'b1111;
    wdata = st_data;
    case (acc_size)
      SZ_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{st_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = st_data;
      end
    endcase
  end

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (ld_funct3)
      LD_LB:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
      LD_LH:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
      LD_LBU:  ld_data = {24'h0, shifted[7:0]};
      LD_LHU:  ld_data = {16'h0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage req/ack sequencer to data memory with pipeline stall generation.
// Optional watchdog enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int size           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            DMemWR_MEM_in,
  input  logic            load_MEM_in,
  input  logic [size-1:0] ALU_out_MEM_in,
  input  logic [size-1:0] data2_MEM_in,
  input  logic [1:0]      store_size_MEM_in,
  input  logic [2:0]      load_size_MEM_in,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [size-1:0] dmem_addr,
  output logic [size-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [size-1:0] dmem_rdata,
  output logic [size-1:0] load_data_out,
  output logic            mem_stall,
  output logic            misalign_err,
  output logic            timeout_err
);

  state_t          state;
  logic            access;
  logic [1:0]      acc_size;
  logic [size-1:0] addr_q;
  logic [size-1:0] data_q;
  logic [1:0]      size_q;
  logic [2:0]      ld_f3_q;
  logic [3:0]      be_c;
  logic [size-1:0] wdata_c;
  logic [size-1:0] ld_c;
  logic            tmo_hit;

  // A store wins when both request lines are high.
  assign access   = DMemWR_MEM_in | load_MEM_in;
  assign acc_size = DMemWR_MEM_in ? store_size_MEM_in : ld_acc_size(load_size_MEM_in);

  assign mem_stall  = ((state == ST_IDLE) && access) || (state == ST_BUSY);
  assign dmem_addr  = {addr_q[size-1:2], 2'b00};
  assign dmem_wdata = wdata_c;
  assign dmem_be    = dmem_req ? be_c : 4'b0000;

  mem_align_unit u_align (
    .addr_lo   (addr_q[1:0]),
    .acc_size  (size_q),
    .st_data   (data_q),
    .rdata     (dmem_rdata),
    .ld_funct3 (ld_f3_q),
    .be        (be_c),
    .wdata     (wdata_c),
    .ld_data   (ld_c)
  );

`ifdef DMEM_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TMO_W-1:0] tmo_cnt;

  // Counter reads zero on the first BUSY cycle, so expiry lands on BUSY cycle TIMEOUT_CYCLES.
  assign tmo_hit = (state == ST_BUSY) && !dmem_ack && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_hit;
      if (state != ST_BUSY) tmo_cnt <= '0;
      else                  tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      size_q        <= SZ_BYTE;
      ld_f3_q       <= LD_LB;
      load_data_out <= '0;
      misalign_err  <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (access) begin
            if (is_misaligned(acc_size, ALU_out_MEM_in[1:0])) begin
              misalign_err  <= 1'b1;
              load_data_out <= '0;
              state         <= ST_DONE;
            end else begin
              dmem_req <= 1'b1;
              dmem_we  <= DMemWR_MEM_in;
              addr_q   <= ALU_out_MEM_in;
              data_q   <= data2_MEM_in;
              size_q   <= acc_size;
              ld_f3_q  <= load_size_MEM_in;
              state    <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            if (!dmem_we) load_data_out <= ld_c;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            state    <= ST_DONE;
          end else if (tmo_hit) begin
            load_data_out <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            state         <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed-vector bench for dmem_access_ctrl with a req/ack memory responder.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        DMemWR_MEM_in = 1'b0;
  logic        load_MEM_in = 1'b0;
  logic [31:0] ALU_out_MEM_in = '0;
  logic [31:0] data2_MEM_in = '0;
  logic [1:0]  store_size_MEM_in = '0;
  logic [2:0]  load_size_MEM_in = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] load_data_out;
  logic        mem_stall;
  logic        misalign_err;
  logic        timeout_err;

  dmem_access_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .DMemWR_MEM_in     (DMemWR_MEM_in),
    .load_MEM_in       (load_MEM_in),
    .ALU_out_MEM_in    (ALU_out_MEM_in),
    .data2_MEM_in      (data2_MEM_in),
    .store_size_MEM_in (store_size_MEM_in),
    .load_size_MEM_in  (load_size_MEM_in),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_be           (dmem_be),
    .dmem_ack          (dmem_ack),
    .dmem_rdata        (dmem_rdata),
    .load_data_out     (load_data_out),
    .mem_stall         (mem_stall),
    .misalign_err      (misalign_err),
    .timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  int          o_stall, o_req, o_burst, o_mis, o_tmo, o_first, o_last;
  int          g_tmo = 0;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_be;
  logic        o_we;
  bit          o_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one access from the current negedge and answers the k-th BUSY cycle
  // with ack (k < 0: never). Returns at the first non-stalled cycle; inputs are
  // left asserted so a following call models a back-to-back instruction.
  task automatic access(input logic we, input logic ld, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] ss, input logic [2:0] ls,
                        input int k, input logic [31:0] rd);
    int   busy;
    logic prev_req;
    DMemWR_MEM_in     = we;
    load_MEM_in       = ld;
    ALU_out_MEM_in    = a;
    data2_MEM_in      = d;
    store_size_MEM_in = ss;
    load_size_MEM_in  = ls;
    o_stall = 0; o_req = 0; o_burst = 0; o_mis = 0; o_tmo = 0;
    o_first = -1; o_last = -1; o_done = 0;
    o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
    busy = 0; prev_req = 1'b0;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (mem_stall) o_stall++;
      if (misalign_err) o_mis++;
      if (timeout_err) begin o_tmo++; g_tmo++; end
      if (dmem_req) begin
        if (!prev_req) begin
          o_burst++;
          o_addr = dmem_addr; o_wdata = dmem_wdata; o_be = dmem_be; o_we = dmem_we;
          if (o_first < 0) o_first = cyc;
        end
        o_last = cyc;
        o_req++;
        if (busy == k) begin dmem_ack = 1'b1; dmem_rdata = rd; end
        busy++;
      end
      prev_req = dmem_req;
      if (c > 0 && !mem_stall) begin o_done = 1; break; end
      @(negedge clk);
      dmem_ack = 1'b0;
    end
    if (!o_done) chk("access_bound", 32'd0, 32'd1);
  endtask

  task automatic bubble();
    DMemWR_MEM_in = 1'b0;
    load_MEM_in   = 1'b0;
    @(negedge clk);
  endtask

  int last1;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_mis", misalign_err, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_ldata", load_data_out, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    access(1, 0, 32'h100, 32'hDEADBEEF, 2'd2, 3'b010, 3, 32'h0);
    chk("sw_be", o_be, 4'b1111);
    chk("sw_wdata", o_wdata, 32'hDEADBEEF);
    chk("sw_addr", o_addr, 32'h100);
    chk("sw_we", o_we, 1);
    chk("sw_stall", o_stall, 5);
    chk("sw_reqcyc", o_req, 4);
    chk("sw_burst", o_burst, 1);
    bubble();

    access(1, 0, 32'h103, 32'h000000A5, 2'd0, 3'b010, 1, 32'h0);
    chk("sb_addr", o_addr, 32'h100);
    chk("sb_be", o_be, 4'b1000);
    chk("sb_wdata", o_wdata, 32'hA5A5A5A5);
    chk("sb_stall", o_stall, 3);
    bubble();

    access(1, 0, 32'h102, 32'h12345678, 2'd1, 3'b010, 0, 32'h0);
    chk("sh_be", o_be, 4'b1100);
    chk("sh_wdata", o_wdata, 32'h56785678);
    bubble();

    access(0, 1, 32'h102, 32'h0, 2'd0, 3'b000, 0, 32'h0080FF00);
    chk("lb_data", load_data_out, 32'hFFFFFF80);
    chk("lb_stall", o_stall, 2);
    chk("lb_be", o_be, 4'b0100);
    chk("lb_we", o_we, 0);
    bubble();
    access(0, 1, 32'h102, 32'h0, 2'd0, 3'b100, 0, 32'h0080FF00);
    chk("lbu_data", load_data_out, 32'h00000080);
    bubble();
    access(0, 1, 32'h102, 32'h0, 2'd0, 3'b001, 0, 32'h0080FF00);
    chk("lh_data", load_data_out, 32'h00000080);
    bubble();
    access(0, 1, 32'h100, 32'h0, 2'd0, 3'b101, 0, 32'h0080FF00);
    chk("lhu_data", load_data_out, 32'h0000FF00);
    bubble();
    access(0, 1, 32'h100, 32'h0, 2'd0, 3'b001, 0, 32'h0080FF00);
    chk("lh0_data", load_data_out, 32'hFFFFFF00);
    bubble();
    access(0, 1, 32'h104, 32'h0, 2'd0, 3'b010, 2, 32'h89ABCDEF);
    chk("lw_data", load_data_out, 32'h89ABCDEF);
    chk("lw_stall", o_stall, 4);
    bubble();
    access(0, 1, 32'h108, 32'h0, 2'd0, 3'b011, 0, 32'h13572468);
    chk("lundef_data", load_data_out, 32'h13572468);
    bubble();

    access(1, 0, 32'h10C, 32'h0BADF00D, 2'd2, 3'b010, 0, 32'hFFFFFFFF);
    chk("st_keeps_ldata", load_data_out, 32'h13572468);
    bubble();

    access(0, 1, 32'h106, 32'h0, 2'd0, 3'b010, 0, 32'h0);
    chk("mis_lw_pulse", o_mis, 1);
    chk("mis_lw_req", o_req, 0);
    chk("mis_lw_stall", o_stall, 1);
    chk("mis_lw_ldata", load_data_out, 0);
    bubble();
    chk("mis_lw_done", misalign_err, 0);
    access(1, 0, 32'h101, 32'h0, 2'd1, 3'b010, 0, 32'h0);
    chk("mis_sh_pulse", o_mis, 1);
    chk("mis_sh_req", o_req, 0);
    bubble();
    access(0, 1, 32'h103, 32'h0, 2'd0, 3'b100, 0, 32'hAB000000);
    chk("lbu3_mis", o_mis, 0);
    chk("lbu3_data", load_data_out, 32'h000000AB);
    bubble();

    access(1, 1, 32'h200, 32'hCAFEF00D, 2'd2, 3'b010, 1, 32'hFFFFFFFF);
    chk("both_we", o_we, 1);
    chk("both_burst", o_burst, 1);
    chk("both_addr", o_addr, 32'h200);
    chk("both_wdata", o_wdata, 32'hCAFEF00D);
    chk("both_ldata", load_data_out, 32'h000000AB);
    bubble();

    access(0, 1, 32'h300, 32'h0, 2'd0, 3'b010, 0, 32'h11111111);
    chk("b2b1_data", load_data_out, 32'h11111111);
    last1 = o_last;
    access(0, 1, 32'h304, 32'h0, 2'd0, 3'b010, 0, 32'h22222222);
    chk("b2b2_data", load_data_out, 32'h22222222);
    chk("b2b2_burst", o_burst, 1);
    chk("b2b_gap", o_first - last1, 3);
    bubble();

    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEAD0000;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    chk("idle_ack_ldata", load_data_out, 32'h22222222);
    chk("idle_ack_req", dmem_req, 0);
    chk("idle_ack_stall", mem_stall, 0);
    @(negedge clk);

    DMemWR_MEM_in = 1'b1; load_MEM_in = 1'b0; ALU_out_MEM_in = 32'h400;
    data2_MEM_in = 32'h5555AAAA; store_size_MEM_in = 2'd2;
    @(negedge clk);
    #1;
    chk("rstbusy_req_pre", dmem_req, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rstbusy_req", dmem_req, 0);
    chk("rstbusy_we", dmem_we, 0);
    chk("rstbusy_addr", dmem_addr, 0);
    chk("rstbusy_wdata", dmem_wdata, 0);
    chk("rstbusy_be", dmem_be, 0);
    chk("rstbusy_ldata", load_data_out, 0);
    DMemWR_MEM_in = 1'b0;
    #1;
    chk("rstbusy_stall", mem_stall, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    access(0, 1, 32'h500, 32'h0, 2'd0, 3'b010, 0, 32'h0F0F0F0F);
    chk("post_rst_data", load_data_out, 32'h0F0F0F0F);
    bubble();

`ifdef DMEM_TIMEOUT_EN
    access(0, 1, 32'h600, 32'h0, 2'd0, 3'b010, -1, 32'h0);
    chk("tmo_pulse", o_tmo, 1);
    chk("tmo_reqcyc", o_req, 255);
    chk("tmo_stall", o_stall, 256);
    chk("tmo_ldata", load_data_out, 0);
    bubble();
`else
    chk("tmo_never", g_tmo, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
